svm_pwm: RTL and testbench

- Three-phase space-vector PWM generator for the motor-drive datapath.
- Takes signed per-phase voltage references and applies min-max (common-mode) injection to produce SVM duty ratios.
- Compares the duties against a center-aligned triangle carrier of programmable half-period and drives three PWM legs.
- Flags each carrier period boundary on halt so upstream control can update references.

---
 rtl/svm_pkg.sv | 22 ++
 rtl/svm_carrier.sv | 64 ++++++
 rtl/svm_pwm.sv | 136 +++++++++++++
 tb/tb_svm_pwm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared definitions for the space-vector PWM generator.
//   D_WIDTH_DEF : default sample / counter width
//   sample_t    : signed voltage reference sample
//   HALF_SCALE  : 2^(D_WIDTH-1), offset moving a signed sample into unsigned range
//   SAT_MAX/MIN : saturation limits of a signed sample
//   dir_e       : carrier counting direction
package svm_pkg;

   localparam int D_WIDTH_DEF = 16;

   typedef logic signed [D_WIDTH_DEF-1:0] sample_t;

   localparam logic [D_WIDTH_DEF-1:0] HALF_SCALE = {1'b1, {(D_WIDTH_DEF-1){1'b0}}};
   localparam sample_t SAT_MAX = {1'b0, {(D_WIDTH_DEF-1){1'b1}}};
   localparam sample_t SAT_MIN = {1'b1, {(D_WIDTH_DEF-1){1'b0}}};

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/svm_carrier.sv
// Center-aligned triangle carrier.
//   clk, rstb   : clock, async active-low reset
//   top_shadow  : peak value to adopt at the next period boundary
//   cnt         : carrier count 0,1..P..1
//   halt        : high while cnt == 0 (period boundary)
//
// state    | meaning
// DIR_UP   | counting towards the latched top
// DIR_DOWN | counting back towards zero
module svm_carrier
   import svm_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic [D_WIDTH-1:0] top_shadow,
   output logic [D_WIDTH-1:0] cnt,
   output logic               halt
);

   localparam logic [D_WIDTH-1:0] ONE = D_WIDTH'(1);

   dir_e               dir_q, dir_d;
   logic [D_WIDTH-1:0] cnt_q, cnt_d;
   logic [D_WIDTH-1:0] top_q, top_d;

   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      top_d = top_q;
      if (cnt_q == '0) begin
         // Period boundary: adopt the new peak; a zero peak parks the carrier at 0.
         top_d = top_shadow;
         dir_d = DIR_UP;
         cnt_d = (top_shadow == '0) ? '0 : ONE;
      end else if (dir_q == DIR_UP) begin
         if (cnt_q == top_q) begin
            dir_d = DIR_DOWN;
            cnt_d = cnt_q - ONE;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end else begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_q <= '0;
         dir_q <= DIR_UP;
         top_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         dir_q <= dir_d;
         top_q <= top_d;
      end
   end

   assign cnt  = cnt_q;
   assign halt = (cnt_q == '0);

endmodule

// File: rtl/svm_pwm.sv
// Three-phase space-vector PWM generator.
//   clk, rstb     : clock, async active-low reset
//   vA, vB, vC    : signed phase references, full scale +/-1
//   periodTop     : carrier peak P (period = 2P cycles)
//   pwmA/B/C      : gate commands, 1 = high-side on
//   halt          : period-boundary strobe
// References pass through a 3-stage shadow pipeline (capture, min-max
// injection, scaling); duties and peak become active only at a period boundary.
module svm_pwm
   import svm_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic [D_WIDTH-1:0] vA,
   input  logic [D_WIDTH-1:0] vB,
   input  logic [D_WIDTH-1:0] vC,
   input  logic [D_WIDTH-1:0] periodTop,
   output logic               pwmA,
   output logic               pwmB,
   output logic               pwmC,
   output logic               halt
);

   localparam int W = D_WIDTH;
   localparam logic signed [W+1:0] SAT_HI = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [W+1:0] SAT_LO = {3'b111, {(W-1){1'b0}}};

   // v + off at W+2 bits, then clip back into the signed W-bit range.
   function automatic logic signed [W-1:0] inject(input logic signed [W-1:0] v,
                                                   input logic signed [W:0]   off);
      logic signed [W+1:0] ext;
      ext = {{2{v[W-1]}}, v} + {off[W], off};
      if (ext > SAT_HI)      inject = {1'b0, {(W-1){1'b1}}};
      else if (ext < SAT_LO) inject = {1'b1, {(W-1){1'b0}}};
      else                   inject = ext[W-1:0];
   endfunction

   // Adding half scale to a signed sample is the same as flipping its MSB.
   function automatic logic [W-1:0] scale(input logic signed [W-1:0] v,
                                          input logic [W-1:0]        p);
      logic [W-1:0]   u;
      logic [2*W-1:0] prod;
      logic [2*W-1:0] q;
      u    = {~v[W-1], v[W-2:0]};
      prod = {{W{1'b0}}, u} * {{W{1'b0}}, p};
      q    = prod >> W;
      scale = (q > {{W{1'b0}}, p}) ? p : q[W-1:0];
   endfunction

   logic signed [W-1:0] s1_va_q, s1_vb_q, s1_vc_q;
   logic [W-1:0]        s1_p_q;
   logic signed [W-1:0] s2_va_q, s2_vb_q, s2_vc_q, s2_va_d, s2_vb_d, s2_vc_d;
   logic [W-1:0]        s2_p_q;
   logic [W-1:0]        s3_ca_q, s3_cb_q, s3_cc_q, s3_ca_d, s3_cb_d, s3_cc_d;
   logic [W-1:0]        s3_p_q;
   logic [W-1:0]        act_ca_q, act_cb_q, act_cc_q, act_ca_d, act_cb_d, act_cc_d;

   logic signed [W-1:0] v_max, v_min;
   logic signed [W:0]   v_sum, v_off;
   logic [W-1:0]        cnt;

   always_comb begin
      v_max = (s1_va_q > s1_vb_q) ? s1_va_q : s1_vb_q;
      if (s1_vc_q > v_max) v_max = s1_vc_q;
      v_min = (s1_va_q < s1_vb_q) ? s1_va_q : s1_vb_q;
      if (s1_vc_q < v_min) v_min = s1_vc_q;
      v_sum = {v_max[W-1], v_max} + {v_min[W-1], v_min};
      v_off = -(v_sum >>> 1);
      s2_va_d = inject(s1_va_q, v_off);
      s2_vb_d = inject(s1_vb_q, v_off);
      s2_vc_d = inject(s1_vc_q, v_off);
   end

   always_comb begin
      s3_ca_d = scale(s2_va_q, s2_p_q);
      s3_cb_d = scale(s2_vb_q, s2_p_q);
      s3_cc_d = scale(s2_vc_q, s2_p_q);
   end

   always_comb begin
      act_ca_d = halt ? s3_ca_q : act_ca_q;
      act_cb_d = halt ? s3_cb_q : act_cb_q;
      act_cc_d = halt ? s3_cc_q : act_cc_q;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         s1_va_q  <= '0;
         s1_vb_q  <= '0;
         s1_vc_q  <= '0;
         s1_p_q   <= '0;
         s2_va_q  <= '0;
         s2_vb_q  <= '0;
         s2_vc_q  <= '0;
         s2_p_q   <= '0;
         s3_ca_q  <= '0;
         s3_cb_q  <= '0;
         s3_cc_q  <= '0;
         s3_p_q   <= '0;
         act_ca_q <= '0;
         act_cb_q <= '0;
         act_cc_q <= '0;
      end else begin
         s1_va_q  <= vA;
         s1_vb_q  <= vB;
         s1_vc_q  <= vC;
         s1_p_q   <= periodTop;
         s2_va_q  <= s2_va_d;
         s2_vb_q  <= s2_vb_d;
         s2_vc_q  <= s2_vc_d;
         s2_p_q   <= s1_p_q;
         s3_ca_q  <= s3_ca_d;
         s3_cb_q  <= s3_cb_d;
         s3_cc_q  <= s3_cc_d;
         s3_p_q   <= s2_p_q;
         act_ca_q <= act_ca_d;
         act_cb_q <= act_cb_d;
         act_cc_q <= act_cc_d;
      end
   end

   svm_carrier #(.D_WIDTH(W)) u_carrier (
      .clk        (clk),
      .rstb       (rstb),
      .top_shadow (s3_p_q),
      .cnt        (cnt),
      .halt       (halt)
   );

   assign pwmA = (cnt < act_ca_q);
   assign pwmB = (cnt < act_cb_q);
   assign pwmC = (cnt < act_cc_q);

endmodule

// File: tb/tb_svm_pwm.sv
module tb_svm_pwm;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic [15:0] va = '0, vb = '0, vc = '0, ptop = '0;
   logic        pwm_a, pwm_b, pwm_c, halt;

   svm_pwm #(.D_WIDTH(16)) dut (
      .clk       (clk),
      .rstb      (rstb),
      .vA        (va),
      .vB        (vb),
      .vC        (vc),
      .periodTop (ptop),
      .pwmA      (pwm_a),
      .pwmB      (pwm_b),
      .pwmC      (pwm_c),
      .halt      (halt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: inputs seen at the last three edges, position inside
   // the current 2P-cycle period, and the duties adopted at the last boundary.
   int h_a[3], h_b[3], h_c[3], h_p[3];
   int pos_m = 0, top_m = 0;
   int act_m[3] = '{0, 0, 0};
   int exp_halt = 1;
   int exp_pwm[3] = '{0, 0, 0};

   function automatic int ref_duty(int v, int mx, int mn, int p);
      int  off, vp;
      longint c;
      off = -((mx + mn) >>> 1);
      vp  = v + off;
      if (vp > 32767)  vp = 32767;
      if (vp < -32768) vp = -32768;
      c = (longint'(vp + 32768) * longint'(p)) / 65536;
      if (c > p) c = p;
      return int'(c);
   endfunction

   function automatic int carrier_val();
      return (pos_m <= top_m) ? pos_m : 2 * top_m - pos_m;
   endfunction

   task automatic model_step();
      int x[3];
      int mx, mn;
      if (!rstb) begin
         for (int i = 0; i < 3; i++) begin
            h_a[i] = 0; h_b[i] = 0; h_c[i] = 0; h_p[i] = 0; act_m[i] = 0;
         end
         pos_m = 0;
         top_m = 0;
      end else begin
         if (pos_m == 0) begin
            x[0] = h_a[2]; x[1] = h_b[2]; x[2] = h_c[2];
            mx = x[0]; mn = x[0];
            for (int i = 1; i < 3; i++) begin
               if (x[i] > mx) mx = x[i];
               if (x[i] < mn) mn = x[i];
            end
            top_m = h_p[2];
            for (int i = 0; i < 3; i++) act_m[i] = ref_duty(x[i], mx, mn, top_m);
            pos_m = (top_m > 0) ? 1 : 0;
         end else begin
            pos_m++;
            if (pos_m == 2 * top_m) pos_m = 0;
         end
         for (int i = 2; i > 0; i--) begin
            h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1]; h_c[i] = h_c[i-1]; h_p[i] = h_p[i-1];
         end
         h_a[0] = int'($signed(va)); h_b[0] = int'($signed(vb));
         h_c[0] = int'($signed(vc)); h_p[0] = int'(ptop);
      end
      exp_halt = (carrier_val() == 0) ? 1 : 0;
      for (int i = 0; i < 3; i++) exp_pwm[i] = (carrier_val() < act_m[i]) ? 1 : 0;
   endtask

   // Per-period measurements of the DUT waveform, closed at each observed halt.
   int cyc = 0, last_halt_cyc = 0, spacing = 0;
   int acc_a = 0, acc_b = 0, acc_c = 0, hi_a = 0, hi_b = 0, hi_c = 0;
   int halt_cnt = 0, pwm_cnt = 0;

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      chk("halt", int'(halt), exp_halt);
      chk("pwmA", int'(pwm_a), exp_pwm[0]);
      chk("pwmB", int'(pwm_b), exp_pwm[1]);
      chk("pwmC", int'(pwm_c), exp_pwm[2]);
      if (halt) begin
         hi_a = acc_a; hi_b = acc_b; hi_c = acc_c;
         acc_a = 0; acc_b = 0; acc_c = 0;
         spacing = cyc - last_halt_cyc;
         last_halt_cyc = cyc;
         halt_cnt++;
      end
      acc_a += int'(pwm_a); acc_b += int'(pwm_b); acc_c += int'(pwm_c);
      pwm_cnt += int'(pwm_a) + int'(pwm_b) + int'(pwm_c);
   endtask

   task automatic wait_halt(input int max_cyc);
      bit seen = 0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         step();
         if (halt) seen = 1;
      end
      if (!seen) chk("halt_timeout", 0, 1);
   endtask

   initial begin
      va = 16'h3FFF; vb = 16'hC000; vc = 16'h0000; ptop = 16'd2048;
      #1;
      chk("rst_halt", int'(halt), 1);
      chk("rst_pwm", int'(pwm_a) + int'(pwm_b) + int'(pwm_c), 0);
      repeat (3) step();
      rstb = 1'b1;

      // Nominal three-phase duties with P = 2048.
      repeat (4200) step();
      wait_halt(5000);
      chk("p2048_hiA", hi_a, 3071);
      chk("p2048_hiB", hi_b, 1023);
      chk("p2048_hiC", hi_c, 2047);
      chk("p2048_spacing", spacing, 4096);

      // All-zero references, P = 100.
      va = '0; vb = '0; vc = '0; ptop = 16'd100;
      wait_halt(5000);
      wait_halt(300);
      chk("zero_hiA", hi_a, 99);
      chk("zero_hiB", hi_b, 99);
      chk("zero_hiC", hi_c, 99);
      chk("zero_spacing", spacing, 200);

      // Mid-period change of vA only takes effect after the next boundary.
      repeat (50) step();
      va = 16'h3FFF;
      wait_halt(300);
      chk("mid_hold_hiA", hi_a, 99);
      wait_halt(300);
      chk("mid_new_hiA", hi_a, 123);
      chk("mid_new_hiB", hi_b, 73);

      // Zero peak parks the carrier, then P = 4.
      va = '0; ptop = '0;
      wait_halt(300);
      halt_cnt = 0; pwm_cnt = 0;
      repeat (10) step();
      chk("p0_halts", halt_cnt, 10);
      chk("p0_pwm", pwm_cnt, 0);
      ptop = 16'd4;
      repeat (6) wait_halt(50);
      chk("p4_spacing", spacing, 8);
      chk("p4_hiA", hi_a, 3);

      // Saturated references.
      va = 16'h7FFF; vb = 16'h7FFF; vc = 16'h8000; ptop = 16'd100;
      repeat (3) wait_halt(300);
      chk("sat_hiA", hi_a, 197);
      chk("sat_hiB", hi_b, 197);
      chk("sat_hiC", hi_c, 0);

      // Randomized references and peaks against the model.
      repeat (15) begin
         va = 16'($urandom); vb = 16'($urandom); vc = 16'($urandom);
         ptop = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
         repeat ($urandom_range(20, 120)) step();
      end

      // Asynchronous reset in the middle of a high pulse.
      va = '0; vb = '0; vc = '0; ptop = 16'd50;
      repeat (3) wait_halt(200);
      step();
      step();
      chk("pre_rst_pwmA", int'(pwm_a), 1);
      #2 rstb = 1'b0;
      #1;
      chk("async_rst_halt", int'(halt), 1);
      chk("async_rst_pwm", int'(pwm_a) + int'(pwm_b) + int'(pwm_c), 0);
      repeat (2) step();
      rstb = 1'b1;
      repeat (300) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
